// File: rtl/z80_bus_master.sv
// Z80 bus initiator: turns single-beat host requests into T1/T2/TW/T3 memory and I/O cycles.
// Define Z80BM_WAIT_EN to honour wait_n and abort cycles stalled for WAIT_TIMEOUT TW states.
module z80_bus_master #(
   parameter int unsigned WAIT_TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic        req_io,
   input  logic [15:0] req_addr,
   input  logic [7:0]  req_data,
   output logic        rsp_valid,
   output logic [7:0]  rsp_data,
   output logic        rsp_err,
   output logic        busy,
   output logic [15:0] A,
   output logic [7:0]  dout,
   input  logic [7:0]  di,
   output logic        mreq_n,
   output logic        iorq_n,
   output logic        rd_n,
   output logic        wr_n,
   output logic        m1_n,
   input  logic        wait_n
);

   typedef enum logic [2:0] {IDLE = 3'd0, T1, T2, TW, T3} state_t;

   state_t      state_q, state_d;
   logic        we_q, we_d, io_q, io_d;
   logic [15:0] addr_q, addr_d;
   logic [7:0]  dout_q, dout_d, rsp_data_q, rsp_data_d;
   logic [3:0]  strb_q, strb_d;
   logic        stall, tmo;

   // active-high {mreq, iorq, rd, wr} for a given state
   function automatic logic [3:0] strobes(input state_t st, input logic we, input logic io);
      logic       act;
      logic [3:0] s;
      act  = (st == T2) || (st == TW);
      s[3] = !io && ((st == T1) || act);
      s[2] = io && act;
      s[1] = !we && (((st == T1) && !io) || act);
      s[0] = we && act;
      return s;
   endfunction

`ifdef Z80BM_WAIT_EN
   localparam logic [7:0] TMO_LIMIT = WAIT_TIMEOUT[7:0];

   logic [7:0] wcnt_q, wcnt_d;
   logic       auto_q, auto_d, err_q, err_d;

   assign stall = ~wait_n;
   assign tmo   = ~wait_n & ~auto_q & (wcnt_q >= TMO_LIMIT);

   // wcnt counts TW states entered because of wait_n; the I/O auto-wait is not one of them
   always_comb begin
      wcnt_d = wcnt_q;
      auto_d = auto_q;
      err_d  = err_q;
      case (state_q)
         T1: begin
            wcnt_d = 8'd0;
            auto_d = 1'b0;
            err_d  = 1'b0;
         end
         T2: begin
            auto_d = io_q;
            if (!io_q && stall) wcnt_d = wcnt_q + 8'd1;
         end
         TW: begin
            if (tmo) begin
               err_d = 1'b1;
            end else if (stall) begin
               auto_d = 1'b0;
               wcnt_d = wcnt_q + 8'd1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wcnt_q <= 8'd0;
         auto_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         wcnt_q <= wcnt_d;
         auto_q <= auto_d;
         err_q  <= err_d;
      end
   end

   assign rsp_err = err_q & (state_q == T3);
`else
   logic unused_cfg;
   assign unused_cfg = wait_n ^ (WAIT_TIMEOUT == 0);
   assign stall      = 1'b0;
   assign tmo        = 1'b0;
   assign rsp_err    = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      we_d       = we_q;
      io_d       = io_q;
      addr_d     = addr_q;
      dout_d     = dout_q;
      rsp_data_d = rsp_data_q;
      case (state_q)
         IDLE, T3: begin
            state_d = IDLE;
            if (req_valid) begin
               state_d = T1;
               we_d    = req_we;
               io_d    = req_io;
               addr_d  = req_addr;
               if (req_we) dout_d = req_data;
            end
         end
         T1: state_d = T2;
         T2: begin
            if (io_q || stall) begin
               state_d = TW;
            end else begin
               state_d = T3;
               if (!we_q) rsp_data_d = di;
            end
         end
         TW: begin
            if (tmo) begin
               state_d = T3;
               if (!we_q) rsp_data_d = 8'hFF;
            end else if (!stall) begin
               state_d = T3;
               if (!we_q) rsp_data_d = di;
            end
         end
         default: state_d = IDLE;
      endcase
      strb_d = strobes(state_d, we_d, io_d);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         we_q       <= 1'b0;
         io_q       <= 1'b0;
         addr_q     <= 16'h0000;
         dout_q     <= 8'h00;
         rsp_data_q <= 8'h00;
         strb_q     <= 4'b0000;
      end else begin
         state_q    <= state_d;
         we_q       <= we_d;
         io_q       <= io_d;
         addr_q     <= addr_d;
         dout_q     <= dout_d;
         rsp_data_q <= rsp_data_d;
         strb_q     <= strb_d;
      end
   end

   assign req_ready = (state_q == IDLE) || (state_q == T3);
   assign rsp_valid = (state_q == T3);
   assign busy      = (state_q != IDLE);
   assign rsp_data  = rsp_data_q;
   assign A         = addr_q;
   assign dout      = dout_q;
   assign mreq_n    = ~strb_q[3];
   assign iorq_n    = ~strb_q[2];
   assign rd_n      = ~strb_q[1];
   assign wr_n      = ~strb_q[0];
   assign m1_n      = 1'b1;

endmodule

// File: tb/tb_z80_bus_master.sv
// Scoreboard bench for z80_bus_master: RAM/IO responder, expected responses queued at accept.
module tb_z80_bus_master;

`ifdef Z80BM_WAIT_EN
   localparam bit WAIT_EN = 1'b1;
`else
   localparam bit WAIT_EN = 1'b0;
`endif
   localparam int TMO = 4;

   logic        clk = 1'b0;
   logic        reset_n = 1'b1;
   logic        req_valid = 1'b0, req_we = 1'b0, req_io = 1'b0;
   logic [15:0] req_addr = 16'h0000;
   logic [7:0]  req_data = 8'h00;
   logic        wait_n = 1'b1;
   logic        req_ready, rsp_valid, rsp_err, busy;
   logic [7:0]  rsp_data, dout, di;
   logic [15:0] A;
   logic        mreq_n, iorq_n, rd_n, wr_n, m1_n;

   typedef struct {
      int          start;
      int          cyc;
      logic [15:0] addr;
      logic        we;
      logic [7:0]  data;
      logic        err;
      int          n_mreq, n_iorq, n_rd, n_wr;
   } exp_t;

   exp_t q[$];
   exp_t mon_e;
   int   total = 0, bad = 0, cyc = 0;
   int   w_lo = 1, w_hi = 0;
   int   n_m = 0, n_i = 0, n_r = 0, n_w = 0;

   logic [7:0] ram [0:65535];
   logic [7:0] ref_mem [0:65535];
   logic [7:0] io_ram [0:255];
   logic [7:0] ref_io [0:255];

   z80_bus_master #(.WAIT_TIMEOUT(TMO)) dut (
      .clk(clk), .reset_n(reset_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_io(req_io),
      .req_addr(req_addr), .req_data(req_data),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy),
      .A(A), .dout(dout), .di(di),
      .mreq_n(mreq_n), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n), .m1_n(m1_n),
      .wait_n(wait_n)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   assign di = !iorq_n ? io_ram[A[7:0]] : ram[A];

   always @(posedge clk) begin
      if (!wr_n && !mreq_n) ram[A] = dout;
      else if (!wr_n && !iorq_n) io_ram[A[7:0]] = dout;
   end

   always @(negedge clk) wait_n = !((cyc + 1) >= w_lo && (cyc + 1) <= w_hi);

   task automatic chk(input string tag, input int got, input int expv);
      total++;
      if (got !== expv) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, got, expv, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (!reset_n) begin
         n_m = 0; n_i = 0; n_r = 0; n_w = 0;
      end else begin
         if (!mreq_n) n_m++;
         if (!iorq_n) n_i++;
         if (!rd_n)   n_r++;
         if (!wr_n)   n_w++;
         if (!mreq_n || !iorq_n) chk("strobe_excl", mreq_n | iorq_n, 1);
         if (q.size() > 0 && cyc >= q[0].start) chk("busy", busy, 1);
         if (rsp_valid) begin
            if (q.size() == 0) begin
               chk("spurious_rsp", rsp_valid, 0);
            end else begin
               mon_e = q.pop_front();
               chk("rsp_cyc", cyc, mon_e.cyc);
               chk("addr", A, mon_e.addr);
               if (mon_e.we) chk("dout", dout, mon_e.data);
               else          chk("rsp_data", rsp_data, mon_e.data);
               chk("rsp_err", rsp_err, mon_e.err);
               chk("n_mreq", n_m, mon_e.n_mreq);
               chk("n_iorq", n_i, mon_e.n_iorq);
               chk("n_rd", n_r, mon_e.n_rd);
               chk("n_wr", n_w, mon_e.n_wr);
               chk("m1_n", m1_n, 1);
            end
            n_m = 0; n_i = 0; n_r = 0; n_w = 0;
         end else if (q.size() > 0 && cyc > q[0].cyc) begin
            chk("rsp_late", rsp_valid, 1);
            mon_e = q.pop_front();
         end
      end
   end

   task automatic send(input logic we, input logic io, input logic [15:0] addr,
                       input logic [7:0] data, input int nwait, input bit tmo);
      exp_t e;
      int   k, w, g, base;
      req_valid = 1'b1; req_we = we; req_io = io; req_addr = addr; req_data = data;
      g = 0;
      while (!req_ready && g < 100) begin
         @(negedge clk);
         g++;
      end
      if (!req_ready) begin
         chk("accept", req_ready, 1);
         req_valid = 1'b0;
         return;
      end
      k    = cyc + 1;
      base = io ? k + 3 : k + 2;
      w    = !WAIT_EN ? 0 : (tmo ? TMO : nwait);
      w_lo = base;
      w_hi = tmo ? base + 40 : base + nwait - 1;
      e.start = k;
      e.cyc   = base + w;
      e.addr  = addr;
      e.we    = we;
      e.err   = WAIT_EN && tmo;
      if (we) begin
         e.data = data;
         if (io) ref_io[addr[7:0]] = data;
         else    ref_mem[addr] = data;
      end else if (WAIT_EN && tmo) begin
         e.data = 8'hFF;
      end else begin
         e.data = io ? ref_io[addr[7:0]] : ref_mem[addr];
      end
      e.n_mreq = io ? 0 : 2 + w;
      e.n_iorq = io ? 2 + w : 0;
      e.n_rd   = we ? 0 : 2 + w;
      e.n_wr   = we ? (io ? 2 + w : 1 + w) : 0;
      q.push_back(e);
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic drain();
      int g;
      g = 0;
      while (q.size() > 0 && g < 60) begin
         @(negedge clk);
         g++;
      end
      if (q.size() > 0) begin
         chk("drain", q.size(), 0);
         q.delete();
      end
      @(negedge clk);
   endtask

   initial begin
      for (int i = 0; i < 65536; i++) begin
         ram[i]     = 8'(i) ^ 8'(i >> 8) ^ 8'h3C;
         ref_mem[i] = ram[i];
      end
      ram[0] = 8'hF3; ref_mem[0] = 8'hF3;
      for (int i = 0; i < 256; i++) begin
         io_ram[i] = ~8'(i);
         ref_io[i] = io_ram[i];
      end

      #1 reset_n = 1'b0;
      #2;
      chk("rst_A", A, 0);
      chk("rst_dout", dout, 0);
      chk("rst_mreq_n", mreq_n, 1);
      chk("rst_iorq_n", iorq_n, 1);
      chk("rst_rd_n", rd_n, 1);
      chk("rst_wr_n", wr_n, 1);
      chk("rst_m1_n", m1_n, 1);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_data", rsp_data, 0);
      chk("rst_rsp_err", rsp_err, 0);
      chk("rst_busy", busy, 0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      chk("rst_req_ready", req_ready, 1);

      send(1'b0, 1'b0, 16'h0000, 8'h00, 0, 1'b0);
      drain();
      send(1'b1, 1'b0, 16'hC000, 8'h5A, 0, 1'b0);
      send(1'b0, 1'b0, 16'hC000, 8'h00, 0, 1'b0);
      drain();
      chk("ram_C000", ram[16'hC000], 8'h5A);
      send(1'b1, 1'b1, 16'h00BF, 8'h80, 0, 1'b0);
      send(1'b0, 1'b1, 16'h00BF, 8'h00, 0, 1'b0);
      send(1'b0, 1'b1, 16'h0042, 8'h00, 2, 1'b0);
      drain();
      send(1'b0, 1'b0, 16'h0020, 8'h00, 3, 1'b0);
      send(1'b1, 1'b0, 16'h0021, 8'hA7, 1, 1'b0);
      drain();
      send(1'b0, 1'b0, 16'h0010, 8'h00, 0, 1'b0);
      send(1'b0, 1'b0, 16'h0011, 8'h00, 0, 1'b0);
      drain();
      send(1'b0, 1'b0, 16'h0030, 8'h00, 0, 1'b1);
      drain();
      send(1'b0, 1'b0, 16'h0021, 8'h00, 0, 1'b0);
      drain();

      for (int i = 0; i < 12; i++)
         send(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              16'h0100 | 16'($urandom_range(0, 7)), 8'($urandom), $urandom_range(0, 2), 1'b0);
      drain();

      send(1'b0, 1'b0, 16'h0040, 8'h00, 0, 1'b0);
      @(negedge clk);
      #2 reset_n = 1'b0;
      q.delete();
      #1;
      chk("midrst_mreq_n", mreq_n, 1);
      chk("midrst_rd_n", rd_n, 1);
      chk("midrst_iorq_n", iorq_n, 1);
      chk("midrst_wr_n", wr_n, 1);
      chk("midrst_busy", busy, 0);
      chk("midrst_rsp_valid", rsp_valid, 0);
      repeat (2) @(negedge clk);
      chk("midrst_A", A, 0);
      chk("midrst_rsp_data", rsp_data, 0);
      reset_n = 1'b1;
      repeat (4) @(negedge clk);
      send(1'b0, 1'b0, 16'h0000, 8'h00, 0, 1'b0);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule

// File: doc/z80_bus_master.md
# z80_bus_master

Synchronous Z80 bus initiator that turns single-beat host requests into Z80-timed memory and I/O cycles. It drives the same strobe set the tv80s core presents to mmu, io and vdp: `mreq_n`, `iorq_n`, `rd_n`, `wr_n`, `m1_n`, `A`, `dout`. It also samples `di` and honours `wait_n`. It lets a debug host, ROM loader or bench exercise the responder side of the system bus without a CPU.

## Interface

**Parameters**
- `WAIT_TIMEOUT`, default 255, range 1..255: maximum consecutive wait-extended TW cycles before the cycle is aborted. Applies only when `Z80BM_WAIT_EN` is defined.

**Ports**
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: host request present.
- `req_ready` out 1: request accepted on any edge where `req_valid & req_ready`.
- `req_we` in 1: 1 = write, 0 = read.
- `req_io` in 1: 1 = I/O cycle, 0 = memory cycle.
- `req_addr` in 16: cycle address.
- `req_data` in 8: write data.
- `rsp_valid` out 1: one-cycle pulse at completion of every accepted request, reads and writes.
- `rsp_data` out 8: read data; holds its last value otherwise.
- `rsp_err` out 1: qualifies `rsp_valid`; set when the cycle ended by timeout.
- `busy` out 1: state is not IDLE.
- `A` out 16: address bus.
- `dout` out 8: data to responders.
- `di` in 8: data from responders.
- `mreq_n`, `iorq_n`, `rd_n`, `wr_n` out 1 each: active-low strobes.
- `m1_n` out 1: tied high; no fetch or IRQ-acknowledge cycles.
- `wait_n` in 1: responder wait request.

## Operation

**States:** IDLE, T1, T2, TW, T3.
- IDLE: `req_ready` = 1. On accept, latch `req_*` and go to T1.
- T1:
  - Drive `A`.
  - Memory cycle: `mreq_n` = 0; read also drives `rd_n` = 0.
  - Write (memory or I/O): `dout` = latched data.
  - Next state is T2.
- T2:
  - Memory read: `mreq_n` = 0 and `rd_n` = 0.
  - Memory write: `mreq_n` = 0 and `wr_n` = 0.
  - I/O cycle: `iorq_n` = 0 plus `rd_n` = 0 or `wr_n` = 0 as the request dictates.
  - Next state:
    - I/O cycle: always TW (mandatory auto-wait).
    - Memory cycle: TW if `wait_n` = 0 is sampled at the end of T2, otherwise T3.
- TW:
  - Strobes held as in T2.
  - Leave for T3 on the first edge where `wait_n` = 1 is sampled.
  - I/O auto-wait: the first TW of an I/O cycle is unconditional; `wait_n` is sampled at its end.
- Read data capture: `di` is captured into `rsp_data` on the edge that moves the machine from T2 or TW into T3.
- T3:
  - All strobes high; `A` and `dout` held.
  - `rsp_valid` = 1.
  - `req_ready` = 1; an accept here goes directly to T1, otherwise to IDLE.
- Strobes come from registered state only, so they are glitch-free. `mreq_n` and `iorq_n` are never low in the same cycle.
- Reset (asynchronous, any state):
  - State goes to IDLE.
  - `A` = 0, `dout` = 0, all strobes = 1, `m1_n` = 1.
  - `rsp_valid` = 0, `rsp_data` = 0x00, `rsp_err` = 0, `busy` = 0, `req_ready` = 1 after release.
  - An in-flight request is dropped with no response.

## Timing

Latencies below are counted in clock cycles.
- Memory cycle, no waits: T1, T2, T3.
  - `rsp_valid` is high in the 3rd cycle after the accept edge.
  - Read: `mreq_n`/`rd_n` low for 2 cycles.
  - Write: `wr_n` low for exactly 1 cycle.
- I/O cycle, no waits: T1, T2, TW, T3.
  - `iorq_n` and `rd_n`/`wr_n` low for 2 cycles; `rsp_valid` in the 4th cycle.
- Each sampled `wait_n` = 0 adds exactly one TW.
- Back-to-back throughput: 3 cycles per memory op, 4 per I/O op, with no idle cycle between ops.
- `req_ready` is combinational from state only; it never depends on `req_valid`.

## Configuration

**`Z80BM_WAIT_EN` defined:**
- `wait_n` is honoured as described above.
- An 8-bit counter counts consecutive TW cycles, excluding the I/O auto-wait.
- When the count reaches `WAIT_TIMEOUT` while `wait_n` = 0, the machine goes to T3 with `rsp_err` = 1. A read returns `rsp_data` = 0xFF.
- The counter clears on every T1.

**`Z80BM_WAIT_EN` undefined:**
- `wait_n` is ignored.
- Memory cycles never enter TW; I/O cycles take exactly one TW.
- `rsp_err` is constant 0; no counter is built.

## Test plan

1. Memory read at 0x0000, responder returns 0xF3, `wait_n` = 1 → `mreq_n`/`rd_n` low 2 cycles; `rsp_valid` 3 cycles after accept with `rsp_data` = 0xF3, `rsp_err` = 0.
2. Memory write 0xC000 ← 0x5A → `mreq_n` low 2 cycles, `wr_n` low 1 cycle (T2), `dout` = 0x5A from T1 through T3; RAM location reads back 0x5A.
3. I/O write to port 0xBF ← 0x80 → `iorq_n` and `wr_n` low 2 cycles, `mreq_n` never low; `rsp_valid` 4 cycles after accept.
4. Memory read with `wait_n` = 0 for 3 sampled edges (`Z80BM_WAIT_EN`) → 3 TW cycles; `di` captured on the edge where `wait_n` = 1; `rsp_valid` 6 cycles after accept.
5. `req_valid` held for two memory reads (0x0010, 0x0011) → second T1 immediately follows first T3; two `rsp_valid` pulses 3 cycles apart; `busy` high throughout.
6. `WAIT_TIMEOUT` = 4, `wait_n` stuck at 0 on a read → `rsp_err` = 1 and `rsp_data` = 0xFF after 4 TW. Separately, `reset_n` asserted mid-T2 → all strobes high within the same cycle, no `rsp_valid`.
